// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM demodulator: phase width, CORDIC arctangent
// table (binary angle units, 32768 = pi) and the discriminator FSM states.
package fm_demod_pkg;

    localparam int PHASE_W = 16;
    localparam int ATAN_N  = 14;

    localparam logic [PHASE_W-1:0] ATAN_TABLE [ATAN_N] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
        16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_DIFF,
        ST_OUT
    } fsm_state_t;

endpackage

// File: rtl/fm_discriminator_if.sv
// Sample-in / frequency-out handshake of the FM discriminator.
interface fm_discriminator_if #(
    parameter int WIDTH = 16
);

    logic                    valid_i;
    logic signed [WIDTH-1:0] i_i;
    logic signed [WIDTH-1:0] q_i;
    logic                    ready_o;
    logic signed [WIDTH-1:0] freq_o;
    logic                    valid_o;
    logic                    overrun_o;

    modport master (
        output valid_i, i_i, q_i,
        input  ready_o, freq_o, valid_o, overrun_o
    );

    modport slave (
        input  valid_i, i_i, q_i,
        output ready_o, freq_o, valid_o, overrun_o
    );

endinterface

// File: rtl/cordic_vec_core.sv
// Iterative vectoring CORDIC: start loads the pre-rotated vector, then one
// micro-rotation per cycle; done marks the cycle of the final rotation.
module cordic_vec_core
    import fm_demod_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic [PHASE_W-1:0]      z_out,
    output logic                    done
);

    // Two guard bits hold the CORDIC gain and the negated -32768 corner.
    localparam int XW  = WIDTH + 2;
    localparam int K_W = 4;

    logic signed [XW-1:0]  x_q, y_q;
    logic signed [XW-1:0]  x_ext, y_ext;
    logic [PHASE_W-1:0]    z_q;
    logic [K_W-1:0]        k_q;
    logic                  busy_q;

    assign x_ext = XW'(x_in);
    assign y_ext = XW'(y_in);
    assign z_out = z_q;
    assign done  = busy_q && (k_q == K_W'(ITER - 1));

    // NOTE: async active-low reset sits in the sensitivity list; all state uses <=
    // so every update below reads the old x/y, as the rotation needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            if (x_ext < 0) begin
                x_q <= -x_ext;
                y_q <= -y_ext;
                z_q <= 16'h8000;
            end else begin
                x_q <= x_ext;
                y_q <= y_ext;
                z_q <= '0;
            end
            k_q    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (!y_q[XW-1]) begin
                x_q <= x_q + (y_q >>> k_q);
                y_q <= y_q - (x_q >>> k_q);
                z_q <= z_q + ATAN_TABLE[k_q];
            end else begin
                x_q <= x_q - (y_q >>> k_q);
                y_q <= y_q + (x_q >>> k_q);
                z_q <= z_q - ATAN_TABLE[k_q];
            end
            if (done) busy_q <= 1'b0;
            else      k_q    <= k_q + 1'b1;
        end
    end

endmodule

// File: rtl/fm_discriminator.sv
// Polar FM discriminator: CORDIC phase per I/Q pair, differenced modulo 2*pi.
// Optional one-pole de-emphasis on the output when FM_DISC_DEEMPH_EN is defined.
module fm_discriminator
    import fm_demod_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ITER     = 14,
    parameter int DEEMPH_K = 4
) (
    input  logic              clk,
    input  logic              rst,
    fm_discriminator_if.slave bus
);

    if (ITER < 8 || ITER > ATAN_N || DEEMPH_K < 1) begin : g_bad_cfg
        $error("fm_discriminator: ITER must be 8..14 and DEEMPH_K >= 1");
    end

    fsm_state_t              state_q, state_d;
    logic signed [WIDTH-1:0] i_q, q_q;
    logic                    zero_q, primed_q, emit_q;
    logic [PHASE_W-1:0]      prev_phase_q, dphi_q, phase_now, z_fin;
    logic                    core_done;
    logic signed [WIDTH-1:0] freq_raw, freq_next;

    cordic_vec_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == ST_PRE),
        .x_in  (i_q),
        .y_in  (q_q),
        .z_out (z_fin),
        .done  (core_done)
    );

    // A zero vector has no angle; holding the old phase yields exactly 0 Hz.
    assign phase_now   = zero_q ? prev_phase_q : z_fin;
    assign freq_raw    = WIDTH'(signed'(dphi_q));
    assign bus.ready_o = (state_q == ST_IDLE);

    // NOTE: next-state defaults to the current state first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.valid_i) state_d = ST_PRE;
            ST_PRE:  state_d = ST_ITER;
            ST_ITER: if (core_done) state_d = ST_DIFF;
            ST_DIFF: state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            i_q           <= '0;
            q_q           <= '0;
            zero_q        <= 1'b0;
            primed_q      <= 1'b0;
            emit_q        <= 1'b0;
            prev_phase_q  <= '0;
            dphi_q        <= '0;
            bus.valid_o   <= 1'b0;
            bus.freq_o    <= '0;
            bus.overrun_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.valid_o <= 1'b0;
            if (bus.valid_i && state_q != ST_IDLE) bus.overrun_o <= 1'b1;
            case (state_q)
                ST_IDLE: if (bus.valid_i) begin
                    i_q <= bus.i_i;
                    q_q <= bus.q_i;
                end
                ST_PRE:  zero_q <= (i_q == '0) && (q_q == '0);
                ST_DIFF: begin
                    dphi_q       <= phase_now - prev_phase_q;
                    prev_phase_q <= phase_now;
                    emit_q       <= primed_q;
                    primed_q     <= 1'b1;
                end
                ST_OUT:  if (emit_q) begin
                    bus.valid_o <= 1'b1;
                    bus.freq_o  <= freq_next;
                end
                default: ;
            endcase
        end
    end

`ifdef FM_DISC_DEEMPH_EN
    // d carries DEEMPH_K fraction bits so small steps are not lost to truncation.
    localparam int DW = WIDTH + DEEMPH_K;

    logic signed [DW-1:0] d_q, d_next, target;
    logic signed [DW:0]   err;

    always_comb begin
        target = {freq_raw, {DEEMPH_K{1'b0}}};
        err    = (DW+1)'(target) - (DW+1)'(d_q);
        d_next = d_q + DW'(err >>> DEEMPH_K);
    end

    assign freq_next = d_next[DW-1:DEEMPH_K];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            d_q <= '0;
        else if (state_q == ST_OUT && emit_q) d_q <= d_next;
    end
`else
    assign freq_next = freq_raw;
`endif

endmodule

// File: tb/tb_fm_discriminator.sv
// Directed bench for fm_discriminator: priming, latency, wrap, zero input,
// overrun, async reset abort, and either raw steps or de-emphasis settling.
module tb_fm_discriminator;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;
    localparam int LAT   = ITER + 3;
    localparam int DK    = 4;
`ifdef FM_DISC_DEEMPH_EN
    localparam int TOL_X = 2;
`else
    localparam int TOL_X = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fm_discriminator_if #(.WIDTH(WIDTH)) bus ();

    fm_discriminator #(.WIDTH(WIDTH), .ITER(ITER), .DEEMPH_K(DK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec   = 0;
    int n_miss  = 0;
    int d_model = 0;
    int n_valid, lat, fval, rdy_at, busy_seen;

    int cx [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                    -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};
    int cy [16] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270,
                    0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_vec++;
        if (got < exp - tol || got > exp + tol) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int expect_out(input int raw);
`ifdef FM_DISC_DEEMPH_EN
        d_model = d_model + ((((raw <<< DK)) - d_model) >>> DK);
        return d_model >>> DK;
`else
        return raw;
`endif
    endfunction

    // Apply one pair and watch 25 cycles; inj > 0 pulses valid_i again that many cycles later.
    task automatic run_pair(input int i, input int q, input int inj = 0);
        int waited = 0;
        n_valid = 0; lat = -1; fval = 0; rdy_at = 0; busy_seen = 0;
        @(negedge clk);
        while (!bus.ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ready_o) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus.i_i = WIDTH'(i);
        bus.q_i = WIDTH'(q);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        busy_seen = !bus.ready_o;
        for (int c = 1; c <= 25; c++) begin
            if (c == inj) bus.valid_i = 1'b1;
            @(posedge clk);
            #1 bus.valid_i = 1'b0;
            if (bus.valid_o) begin
                n_valid++;
                if (lat < 0) begin
                    lat    = c;
                    fval   = int'(bus.freq_o);
                    rdy_at = int'(bus.ready_o);
                end
            end
        end
    endtask

    task automatic expect_pair(input string tag, input int raw, input int tol);
        int exp;
        exp = expect_out(raw);
        check({tag, "_busy"}, busy_seen, 1);
        check({tag, "_nvalid"}, n_valid, 1);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_ready"}, rdy_at, 1);
        check({tag, "_freq"}, fval, exp, tol + TOL_X);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.i_i     = '0;
        bus.q_i     = '0;
        #22;
        check("rst_ready", int'(bus.ready_o), 1);
        check("rst_valid", int'(bus.valid_o), 0);
        check("rst_freq", int'(bus.freq_o), 0);
        check("rst_overrun", int'(bus.overrun_o), 0);
        @(negedge clk) rst = 1'b1;

        run_pair(16384, 0);
        check("prime_nvalid", n_valid, 0);
        run_pair(0, 16384);
        expect_pair("quarter", 16384, 2);

        run_pair(-16384, 100);
        expect_pair("neg_x", 16320, 3);
        run_pair(-16384, -100);
        expect_pair("wrap", 128, 2);
        run_pair(16384, 0);
        expect_pair("half", 32704, 3);

        run_pair(0, 0);
        expect_pair("zero_in", 0, 0);
        run_pair(16384, 0);
        expect_pair("after_zero", 0, 0);

        run_pair(0, 16384, 5);
        expect_pair("ovr_pair", 16384, 2);
        check("ovr_set", int'(bus.overrun_o), 1);
        run_pair(16384, 0);
        expect_pair("ovr_next", -16384, 2);
        check("ovr_sticky", int'(bus.overrun_o), 1);

        // Abort mid-iteration, eight cycles after the accept edge.
        @(negedge clk);
        bus.i_i = WIDTH'(0);
        bus.q_i = WIDTH'(16384);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", int'(bus.ready_o), 1);
        check("abort_valid", int'(bus.valid_o), 0);
        check("abort_freq", int'(bus.freq_o), 0);
        check("abort_overrun", int'(bus.overrun_o), 0);
        d_model = 0;
        @(negedge clk) rst = 1'b1;
        run_pair(0, 16384);
        check("reprime_nvalid", n_valid, 0);
        run_pair(16384, 0);
        expect_pair("reprime_next", -16384, 2);

`ifdef FM_DISC_DEEMPH_EN
        begin
            int prev = -40000;
            int mono = 1;
            for (int n = 1; n <= 100; n++) begin
                run_pair(cx[n % 16], cy[n % 16]);
                if (n_valid != 1) mono = 0;
                if (fval < prev && fval < 4000) mono = 0;
                prev = fval;
            end
            check("deemph_mono", mono, 1);
            check("deemph_final", fval, 4096, 16);
        end
`else
        for (int n = 1; n <= 17; n++) begin
            run_pair(cx[n % 16], cy[n % 16]);
            check("step_nvalid", n_valid, 1);
            check("step_freq", fval, 4096, 8);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fm_discriminator.md
# fm_discriminator

Polar FM discriminator downstream of the I and Q channel 17-tap low-pass FIRs at fs = 200 kHz. Each I/Q sample pair's phase is computed with an iterative CORDIC in vectoring mode. The previous phase is subtracted modulo 2π, giving one signed instantaneous-frequency sample per input pair. The output feeds the audio decimation stage.

## Interface
- WIDTH, 16: I/Q input and frequency output width (signed).
- ITER, 14: CORDIC micro-rotations; legal range 8..14.
- DEEMPH_K, 4: de-emphasis shift; used only when FM_DISC_DEEMPH_EN is defined.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  one-cycle strobe: i_i/q_i hold a new filtered pair.
- i_i  in  WIDTH  signed in-phase sample (FIR data_o, 16.0).
- q_i  in  WIDTH  signed quadrature sample.
- ready_o  out  1  high when a new pair can be accepted (FSM in IDLE).
- freq_o  out  WIDTH  signed frequency; full scale ±32768 = ±π rad/sample.
- valid_o  out  1  one-cycle strobe: freq_o updated.
- overrun_o  out  1  sticky; valid_i arrived while ready_o low.

## Operation
- Phase format: 16-bit binary angle; +32767 ≈ +π, −32768 = −π. Wrap-around is native two's-complement.
- FSM states:
  - IDLE: ready_o = 1. On valid_i, register i_i/q_i and go to PRE.
  - PRE: if x < 0, negate x and y and set z = −32768; else z = 0. If I = Q = 0, set the zero flag.
  - ITER: run k = 0..ITER−1, one per cycle.
  - DIFF: compute the phase difference.
  - OUT: update outputs; return to IDLE.
- Datapath: x, y are WIDTH+2 bits, sign-extended. The guard bits absorb CORDIC gain 1.647 and |−32768|.
- Vectoring step k:
  - if y ≥ 0: x += y>>>k, y −= x>>>k, z += ATAN[k].
  - else: x −= y>>>k, y += x>>>k, z −= ATAN[k].
  - Use the old x and y on both sides of each update.
- ATAN[0..13] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1.
- Zero input: if the zero flag is set, the phase is forced to prev_phase, so the frequency is 0.
- DIFF: freq = z − prev_phase, truncated to WIDTH bits. Modulo wrap gives the correct unwrapped result for |Δφ| < π. Then prev_phase ← z.
- First pair after reset only primes prev_phase; valid_o stays low for that pair (primed flag).
- valid_i while not in IDLE: sample dropped, overrun_o set. overrun_o clears only on reset.
- Magnitude (final x) is discarded.

## Timing
- Accept edge = cycle 0. PRE = cycle 1. ITER = cycles 2..ITER+1. DIFF = cycle ITER+2. OUT = cycle ITER+3.
- valid_o pulses at cycle ITER+3; 17 cycles for default ITER.
- ready_o returns high in the cycle after OUT. Minimum input spacing is ITER+4 cycles, far below one 200 kHz period at any practical clk.
- valid_i in the same cycle that ready_o rises is accepted.
- Reset values: ready_o = 1, valid_o = 0, freq_o = 0, overrun_o = 0. Also prev_phase = 0, primed = 0, FSM = IDLE.
- Reset mid-iteration aborts immediately. No valid_o for the aborted pair; the next pair is treated as the first.

## Configuration
- FM_DISC_DEEMPH_EN defined: a one-pole de-emphasis runs in the OUT state before freq_o is updated:
  - d ← d + ((freq − d) >>> DEEMPH_K), with WIDTH+DEEMPH_K internal bits and d reset to 0.
  - freq_o = d truncated; latency unchanged.
- Undefined: freq_o is the raw phase difference and no filter registers exist.

## Structure
- Shared package fm_demod_pkg:
  - PHASE_W = 16
  - ATAN_TABLE constant array
  - FSM state enum (IDLE, PRE, ITER, DIFF, OUT)
- Sub-module cordic_vec_core: pre-rotation plus iterative vectoring.
  - Ports: start, x/y in, z out, done.
  - fm_discriminator wraps it with the handshake, differentiator, de-emphasis and flags.

## Test plan
- (16384, 0) then (0, 16384): first pair gives no valid_o; second gives freq_o = 16384 ±2 at cycle 17 after accept.
- (−16384, 100) then (−16384, −100): phases ≈ +32704 / −32704; freq_o = +128 ±2, proving wrap.
- (16384, 0) primes the phase, then (0, 0): freq_o = 0 exactly; next pair (16384, 0) also yields 0.
- valid_i pulsed 5 cycles after an accept: overrun_o = 1 and stays 1; only one valid_o produced.
- rst low at cycle 8 of an iteration: all outputs return to reset values asynchronously. After release, the first pair produces no valid_o.
- With FM_DISC_DEEMPH_EN defined and constant Δφ = 4096 per pair: freq_o rises monotonically, reaching 4096 ±16 within 100 samples.
